// File: rtl/mxv_pkg.sv
// Shared types and width helpers for the streaming matrix-by-vector engine.
package mxv_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_VEC = 2'd1,
        COMPUTE  = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    function automatic int dim_width(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    // Room for a full-width product plus growth from summing max_dim of them.
    function automatic int acc_width(input int word_length, input int max_dim);
        return 2 * word_length + $clog2(max_dim);
    endfunction

    function automatic int lane_lsb(input int lane, input int word_length);
        return lane * word_length;
    endfunction

endpackage

// File: rtl/mxv_stream_engine_if.sv
// Vector, matrix and result streams between host, engine and result consumer.
interface mxv_stream_engine_if #(
    parameter int WORD_LENGTH = 8,
    parameter int LANES       = 4,
    parameter int ACC_W       = 20
);
    // Every stream moves one item on a clk edge where valid && ready; the
    // producer holds data stable while valid && !ready, and ready never waits on valid.
    logic [WORD_LENGTH-1:0]       v_data;
    logic                         v_valid;
    logic                         v_ready;
    logic [LANES*WORD_LENGTH-1:0] m_data;
    logic                         m_valid;
    logic                         m_ready;
    logic [ACC_W-1:0]             r_data;
    logic                         r_valid;
    logic                         r_ready;

    modport master (
        output v_data, v_valid, m_data, m_valid, r_ready,
        input  v_ready, m_ready, r_data, r_valid
    );

    modport slave (
        input  v_data, v_valid, m_data, m_valid, r_ready,
        output v_ready, m_ready, r_data, r_valid
    );

endinterface

// File: rtl/mxv_result_fifo.sv
// Synchronous result FIFO; head is presented combinationally and reads as zero when empty.
module mxv_result_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mxv_stream_engine.sv
// Run-time sized matrix-by-vector engine: load vector, stream the matrix row-major
// LANES elements per beat, and queue one accumulated result per row.
module mxv_stream_engine
    import mxv_pkg::*;
#(
    parameter int WORD_LENGTH = 8,
    parameter int LANES       = 4,
    parameter int MAX_DIM     = 16,
    parameter int RES_DEPTH   = 8,
    parameter int DIM_W       = dim_width(MAX_DIM),
    parameter int ACC_W       = acc_width(WORD_LENGTH, MAX_DIM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [DIM_W-1:0]             dim,
    input  logic                         signed_mode,
    mxv_stream_engine_if.slave           stream,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output state_t                       dbg_state,
    output logic [$clog2(RES_DEPTH+1)-1:0] dbg_level
);
    localparam int W         = WORD_LENGTH;
    localparam int BEATS_MAX = (MAX_DIM + LANES - 1) / LANES;
    localparam int BEAT_W    = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam int VEC_N     = BEATS_MAX * LANES;
    localparam int IDX_W     = (VEC_N > 1) ? $clog2(VEC_N) : 1;

    state_t           state_q, state_d;
    logic [DIM_W-1:0] dim_q, dim_last, vcnt_q, row_q;
    logic             signed_q;
    logic [BEAT_W-1:0] beat_q, last_beat_q;
    logic [ACC_W-1:0] acc_q, partial, row_sum;
    logic [W-1:0]     vec [VEC_N];
    logic [ACC_W-1:0] prod [LANES];
    logic             dim_ok, v_fire, m_fire, row_end, fifo_empty, fifo_full;

    assign dim_ok          = (dim != '0) && (int'(dim) <= MAX_DIM);
    assign dim_last        = dim_q - DIM_W'(1);
    assign stream.v_ready  = (state_q == LOAD_VEC);
    assign stream.m_ready  = (state_q == COMPUTE) && !fifo_full;
    assign stream.r_valid  = !fifo_empty;
    assign v_fire          = stream.v_valid && stream.v_ready;
    assign m_fire          = stream.m_valid && stream.m_ready;
    assign row_end         = m_fire && (beat_q == last_beat_q);
    assign row_sum         = acc_q + partial;
    assign busy            = (state_q != IDLE);
    assign dbg_state       = state_q;

    // Operands are widened to 2W (sign or zero) so one multiplier serves both modes.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IDX_W-1:0] col;
        logic             live;
        logic [W-1:0]     a, x;
        logic [2*W-1:0]   a_ext, x_ext, p;

        assign col   = IDX_W'(int'(beat_q) * LANES + k);
        assign live  = (int'(beat_q) * LANES + k) < int'(dim_q);
        assign a     = stream.m_data[lane_lsb(k, W) +: W];
        assign x     = vec[col];
        assign a_ext = {{W{signed_q & a[W-1]}}, a};
        assign x_ext = {{W{signed_q & x[W-1]}}, x};
        assign p     = a_ext * x_ext;
        assign prod[k] = live ? {{(ACC_W-2*W){signed_q & p[2*W-1]}}, p} : '0;
    end

    always_comb begin
        partial = '0;
        for (int k = 0; k < LANES; k++) partial = partial + prod[k];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start && dim_ok) state_d = LOAD_VEC;
            LOAD_VEC: if (v_fire && vcnt_q == dim_last) state_d = COMPUTE;
            COMPUTE:  if (row_end && row_q == dim_last) state_d = DRAIN;
            DRAIN:    if (fifo_empty) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (v_fire) vec[IDX_W'(vcnt_q)] <= stream.v_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            dim_q       <= '0;
            signed_q    <= 1'b0;
            vcnt_q      <= '0;
            row_q       <= '0;
            beat_q      <= '0;
            last_beat_q <= '0;
            acc_q       <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == DRAIN) && fifo_empty;
            err     <= (state_q == IDLE) && start && !dim_ok;
            case (state_q)
                IDLE: if (start && dim_ok) begin
                    dim_q       <= dim;
                    signed_q    <= signed_mode;
                    last_beat_q <= BEAT_W'((int'(dim) + LANES - 1) / LANES - 1);
                    vcnt_q      <= '0;
                    row_q       <= '0;
                    beat_q      <= '0;
                    acc_q       <= '0;
                end
                LOAD_VEC: if (v_fire) vcnt_q <= vcnt_q + DIM_W'(1);
                COMPUTE: if (m_fire) begin
                    if (beat_q == last_beat_q) begin
                        acc_q  <= '0;
                        beat_q <= '0;
                        row_q  <= row_q + DIM_W'(1);
                    end else begin
                        acc_q  <= row_sum;
                        beat_q <= beat_q + BEAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    mxv_result_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (row_end),
        .pop   (stream.r_ready),
        .din   (row_sum),
        .dout  (stream.r_data),
        .count (dbg_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule

// File: tb/tb_mxv_stream_engine.sv
// Bench for mxv_stream_engine: fixed vectors, hand-built corner sequences and random jobs.
module tb_mxv_stream_engine;
    import mxv_pkg::*;

    localparam int W         = 8;
    localparam int LANES     = 4;
    localparam int MAX_DIM   = 16;
    localparam int RES_DEPTH = 4;
    localparam int DIM_W     = dim_width(MAX_DIM);
    localparam int ACC_W     = acc_width(W, MAX_DIM);
    localparam int CNT_W     = $clog2(RES_DEPTH + 1);
    localparam int BUDGET    = 300;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DIM_W-1:0] dim;
    logic             signed_mode;
    logic             busy, done, err;
    state_t           dbg_state;
    logic [CNT_W-1:0] dbg_level;

    mxv_stream_engine_if #(.WORD_LENGTH(W), .LANES(LANES), .ACC_W(ACC_W)) bus ();

    mxv_stream_engine #(
        .WORD_LENGTH (W),
        .LANES       (LANES),
        .MAX_DIM     (MAX_DIM),
        .RES_DEPTH   (RES_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dim         (dim),
        .signed_mode (signed_mode),
        .stream      (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state   (dbg_state),
        .dbg_level   (dbg_level)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int               total = 0;
    int               bad = 0;
    int               done_cnt = 0;
    int               err_cnt = 0;
    int               rr_mode = 0;
    bit               hung = 1'b0;
    logic [ACC_W-1:0] exp_q[$];
    int               vec_m [MAX_DIM];
    int               mat_m [MAX_DIM][MAX_DIM];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (bus.r_valid === 1'b1 && bus.r_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got %0d expected none", bus.r_data);
            end else begin
                check("result", bus.r_data, exp_q.pop_front());
            end
        end
    end

    // r_ready: 0 = held low, 1 = always high, 2 = random
    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.r_ready = 1'b0;
            1:       bus.r_ready = 1'b1;
            default: bus.r_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- reference model ----------------
    function automatic longint ext(input int x, input bit sm);
        int v;
        v = x & 255;
        if (sm && v >= 128) v = v - 256;
        return longint'(v);
    endfunction

    task automatic push_model(input int d, input bit sm);
        longint s;
        for (int r = 0; r < d; r++) begin
            s = 0;
            for (int c = 0; c < d; c++) s += ext(mat_m[r][c], sm) * ext(vec_m[c], sm);
            exp_q.push_back(ACC_W'(s));
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input bit is_matrix);
        int n;
        n = 0;
        if (hung) return;
        forever begin
            @(negedge clk);
            if ((is_matrix ? bus.m_ready : bus.v_ready) === 1'b1) begin
                tick();
                return;
            end
            n++;
            if (n > BUDGET) begin
                total++;
                bad++;
                hung = 1'b1;
                $display("FAIL handshake_timeout: got no ready in %0d cycles expected ready (matrix=%0d)", BUDGET, is_matrix);
                tick();
                return;
            end
        end
    endtask

    task automatic start_job(input int d, input bit sm);
        start = 1'b1;
        dim = DIM_W'(d);
        signed_mode = sm;
        tick();
        start = 1'b0;
    endtask

    task automatic send_vec(input int d, input bit gaps);
        for (int i = 0; i < d; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            bus.v_data = W'(vec_m[i]);
            bus.v_valid = 1'b1;
            wait_hs(1'b0);
            bus.v_valid = 1'b0;
        end
    endtask

    task automatic send_rows(input int d, input int r0, input int r1, input bit rand_pad, input bit gaps);
        int nb;
        int c;
        int lane;
        nb = (d + LANES - 1) / LANES;
        for (int r = r0; r <= r1; r++) begin
            for (int b = 0; b < nb; b++) begin
                if (gaps) repeat ($urandom_range(0, 2)) tick();
                for (int k = 0; k < LANES; k++) begin
                    c = b * LANES + k;
                    lane = (c < d) ? mat_m[r][c] : (rand_pad ? int'($urandom_range(0, 255)) : 255);
                    bus.m_data[k*W +: W] = W'(lane);
                end
                bus.m_valid = 1'b1;
                wait_hs(1'b1);
                bus.m_valid = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < BUDGET * 4) begin
            tick();
            n++;
        end
        if (done_cnt == d0) $display("FAIL %s_done_timeout: got no done expected done", name);
        repeat (2) tick();
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_results_left"}, exp_q.size(), 0);
    endtask

    task automatic run_job(input string name, input int d, input bit sm, input bit rand_pad, input bit gaps);
        int d0;
        d0 = done_cnt;
        start_job(d, sm);
        send_vec(d, gaps);
        send_rows(d, 0, d - 1, rand_pad, gaps);
        wait_done(name, d0);
    endtask

    task automatic load_identity(input int d);
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++) mat_m[r][c] = (r == c) ? 1 : 0;
        for (int i = 0; i < d; i++) vec_m[i] = i + 1;
    endtask

    task automatic load_random(input int d);
        for (int i = 0; i < d; i++) vec_m[i] = int'($urandom_range(0, 255));
        for (int r = 0; r < d; r++)
            for (int c = 0; c < d; c++) mat_m[r][c] = int'($urandom_range(0, 255));
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        bit sm;
        int v0, v1, m0, m1;
        int exp0;
    } case_t;

    case_t tbl [6];

    initial begin
        int d0;
        int e0;
        int d;
        bit sm;

        tbl[0] = '{1'b1, 'hFF, 'h02, 'h03, 'h04, 5};
        tbl[1] = '{1'b0, 'hFF, 'h02, 'h03, 'h04, 773};
        tbl[2] = '{1'b1, 'h80, 'h80, 'h80, 'h80, 32768};
        tbl[3] = '{1'b0, 'hFF, 'hFF, 'hFF, 'hFF, 130050};
        tbl[4] = '{1'b1, 'h7F, 'h81, 'h02, 'h03, 'hFFF81};
        tbl[5] = '{1'b1, 'h80, 'h7F, 'h7F, 'h80, 'hF8100};

        reset = 1'b0;
        start = 1'b0;
        dim = '0;
        signed_mode = 1'b0;
        bus.v_data = '0;
        bus.v_valid = 1'b0;
        bus.m_data = '0;
        bus.m_valid = 1'b0;
        bus.r_ready = 1'b0;
        repeat (3) tick();

        check("reset_v_ready", bus.v_ready, 0);
        check("reset_m_ready", bus.m_ready, 0);
        check("reset_r_valid", bus.r_valid, 0);
        check("reset_r_data", bus.r_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_level", dbg_level, 0);
        reset = 1'b1;
        tick();

        // identity, dim=4
        rr_mode = 1;
        load_identity(4);
        for (int i = 1; i <= 4; i++) exp_q.push_back(ACC_W'(i));
        run_job("identity", 4, 1'b0, 1'b0, 1'b0);

        // dim=5: two beats per row, padded lanes carry 0xFF
        for (int i = 0; i < 5; i++) vec_m[i] = 2;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) mat_m[r][c] = 1;
        repeat (5) exp_q.push_back(ACC_W'(10));
        run_job("padding", 5, 1'b0, 1'b0, 1'b0);

        // dim=2 signed/unsigned table; row 1 is zero
        foreach (tbl[i]) begin
            vec_m[0] = tbl[i].v0;
            vec_m[1] = tbl[i].v1;
            mat_m[0][0] = tbl[i].m0;
            mat_m[0][1] = tbl[i].m1;
            mat_m[1][0] = 0;
            mat_m[1][1] = 0;
            exp_q.push_back(ACC_W'(tbl[i].exp0));
            exp_q.push_back('0);
            run_job($sformatf("table%0d", i), 2, tbl[i].sm, 1'b0, 1'b0);
        end

        // backpressure: FIFO fills after four rows, then drains in order
        rr_mode = 0;
        repeat (2) tick();
        load_random(8);
        sm = 1'($urandom_range(0, 1));
        push_model(8, sm);
        d0 = done_cnt;
        start_job(8, sm);
        send_vec(8, 1'b0);
        check("bp_r_valid_before", bus.r_valid, 0);
        send_rows(8, 0, 0, 1'b1, 1'b0);
        check("bp_latency_r_valid", bus.r_valid, 1);
        send_rows(8, 1, 3, 1'b1, 1'b0);
        repeat (3) tick();
        check("bp_m_ready_low", bus.m_ready, 0);
        check("bp_level_full", dbg_level, RES_DEPTH);
        check("bp_busy", busy, 1);
        rr_mode = 1;
        send_rows(8, 4, 7, 1'b1, 1'b0);
        wait_done("backpressure", d0);

        // illegal starts
        e0 = err_cnt;
        start_job(0, 1'b0);
        check("err_dim0_pulse", err, 1);
        check("err_dim0_busy", busy, 0);
        check("err_dim0_v_ready", bus.v_ready, 0);
        tick();
        check("err_dim0_clear", err, 0);
        start_job(MAX_DIM + 1, 1'b0);
        check("err_dimmax_pulse", err, 1);
        check("err_dimmax_busy", busy, 0);
        check("err_dimmax_v_ready", bus.v_ready, 0);
        repeat (2) tick();
        check("err_pulse_count", err_cnt - e0, 2);

        // reset mid-COMPUTE; a stray start while busy must be ignored
        rr_mode = 0;
        repeat (2) tick();
        load_identity(4);
        d0 = done_cnt;
        e0 = err_cnt;
        start_job(4, 1'b0);
        send_vec(4, 1'b0);
        send_rows(4, 0, 1, 1'b0, 1'b0);
        check("mid_state_compute", dbg_state, COMPUTE);
        start_job(0, 1'b0);
        tick();
        check("busy_start_no_err", err_cnt - e0, 0);
        reset = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_r_valid", bus.r_valid, 0);
        check("abort_m_ready", bus.m_ready, 0);
        check("abort_level", dbg_level, 0);
        reset = 1'b1;
        repeat (3) tick();
        check("abort_no_done", done_cnt - d0, 0);
        rr_mode = 1;
        load_identity(4);
        for (int i = 1; i <= 4; i++) exp_q.push_back(ACC_W'(i));
        run_job("after_reset", 4, 1'b0, 1'b0, 1'b0);

        // random jobs against the model
        for (int j = 0; j < 12; j++) begin
            d = (j == 0) ? MAX_DIM : (j == 1) ? 1 : int'($urandom_range(1, MAX_DIM));
            sm = 1'($urandom_range(0, 1));
            rr_mode = int'($urandom_range(1, 2));
            load_random(d);
            push_model(d, sm);
            run_job($sformatf("random%0d_dim%0d", j, d), d, sm, 1'b1, 1'($urandom_range(0, 1)));
        end

        rr_mode = 1;
        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
